// File: rtl/miller_decoder.sv
// Miller line decoder: synchronises the serial line, tracks bit phase from edges,
// and delivers one valid-pulsed NRZ bit per bit period with frame framing pulses.
module miller_decoder #(
   parameter int CLK_PER_BIT = 16,
   parameter int FRAME_BITS  = 8,
   parameter int TOL         = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic Miller_BitIn,
   output logic Bit_in,
   output logic Bit_in_valid,
   output logic frame_start,
   output logic frame_done,
   output logic frame_err
);

   localparam int HALF     = CLK_PER_BIT / 2;
   localparam int PH_W     = $clog2(CLK_PER_BIT);
   localparam int IDLE_W   = $clog2(2 * CLK_PER_BIT + 1);

   localparam logic [PH_W-1:0]   PH_ONE     = PH_W'(1);
   localparam logic [PH_W-1:0]   PH_LAST    = PH_W'(CLK_PER_BIT - 1);
   localparam logic [PH_W-1:0]   MID_LO     = PH_W'(HALF - TOL);
   localparam logic [PH_W-1:0]   MID_HI     = PH_W'(HALF + TOL);
   localparam logic [PH_W-1:0]   MID_RESYNC = PH_W'(HALF + 1);
   localparam logic [PH_W-1:0]   LATE_HI    = PH_W'(TOL);
   localparam logic [PH_W-1:0]   EARLY_LO   = PH_W'(CLK_PER_BIT - TOL);
   localparam logic [IDLE_W-1:0] IDLE_MAX   = IDLE_W'(2 * CLK_PER_BIT);
   localparam logic [7:0]        LAST_BIT   = 8'(FRAME_BITS - 1);

   typedef enum logic [1:0] {HUNT, ARMED, START, DATA} state_t;

   state_t            state;
   logic              sync1, sync2, prev;
   logic [PH_W-1:0]   ph;
   logic [IDLE_W-1:0] idle_cnt;
   logic [7:0]        bit_cnt;
   logic              mid_seen;

   logic              line_edge;
   logic              rise;
   logic              is_mid, is_late, is_early, is_last;
   logic              emit, bad, mid_nxt;
   logic [PH_W-1:0]   ph_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         prev  <= 1'b0;
      end else begin
         sync1 <= Miller_BitIn;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   assign line_edge = sync2 ^ prev;
   assign rise      = line_edge & sync2;

   assign is_mid   = (ph >= MID_LO) && (ph <= MID_HI);
   assign is_late  = (ph <= LATE_HI);
   assign is_early = (ph >= EARLY_LO);
   assign is_last  = (ph == PH_LAST);

   // Every accepted edge re-anchors ph, so tolerance applies edge-to-edge
   // and jitter never accumulates across a frame.
   always_comb begin
      emit    = 1'b0;
      bad     = 1'b0;
      mid_nxt = mid_seen;
      ph_nxt  = is_last ? '0 : ph + PH_ONE;
      if (line_edge) begin
         if (is_mid) begin
            if (mid_seen) bad = 1'b1;
            mid_nxt = 1'b1;
            ph_nxt  = MID_RESYNC;
         end else if (is_late) begin
            ph_nxt = PH_ONE;
         end else if (is_early) begin
            emit   = 1'b1;
            ph_nxt = PH_ONE;
         end else begin
            bad = 1'b1;
         end
      end else if (is_last) begin
         emit = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= HUNT;
         ph           <= '0;
         idle_cnt     <= '0;
         bit_cnt      <= '0;
         mid_seen     <= 1'b0;
         Bit_in       <= 1'b0;
         Bit_in_valid <= 1'b0;
         frame_start  <= 1'b0;
         frame_done   <= 1'b0;
         frame_err    <= 1'b0;
      end else begin
         Bit_in_valid <= 1'b0;
         frame_start  <= 1'b0;
         frame_done   <= 1'b0;
         frame_err    <= 1'b0;
         case (state)
            HUNT: begin
               if (line_edge || sync2)    idle_cnt <= '0;
               else if (idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + 1'b1;
               if (idle_cnt == IDLE_MAX) state <= ARMED;
            end
            ARMED: begin
               // idle_cnt only grows while the line is low, so the first edge here is a rise
               if (rise) begin
                  ph       <= PH_ONE;
                  mid_seen <= 1'b0;
                  state    <= START;
               end
            end
            START, DATA: begin
               if (bad) begin
                  frame_err <= 1'b1;
                  idle_cnt  <= '0;
                  state     <= HUNT;
               end else begin
                  ph       <= ph_nxt;
                  mid_seen <= emit ? 1'b0 : mid_nxt;
                  if (emit) begin
                     if (state == START) begin
                        if (mid_seen) begin
                           frame_err <= 1'b1;
                           idle_cnt  <= '0;
                           state     <= HUNT;
                        end else begin
                           frame_start <= 1'b1;
                           bit_cnt     <= '0;
                           state       <= DATA;
                        end
                     end else begin
                        Bit_in       <= mid_seen;
                        Bit_in_valid <= 1'b1;
                        bit_cnt      <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                           frame_done <= 1'b1;
                           idle_cnt   <= '0;
                           state      <= HUNT;
                        end
                     end
                  end
               end
            end
            default: state <= HUNT;
         endcase
      end
   end

endmodule

// File: tb/tb_miller_decoder.sv
// Directed bench for miller_decoder: table of frames plus hand sequences for
// hunt behaviour and reset in mid-frame.
module tb_miller_decoder;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic line = 1'b0;
   logic bit_o, valid_o, start_o, done_o, err_o;

   always #5 clk = ~clk;

   miller_decoder #(.CLK_PER_BIT(16), .FRAME_BITS(8), .TOL(3)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .Miller_BitIn (line),
      .Bit_in       (bit_o),
      .Bit_in_valid (valid_o),
      .frame_start  (start_o),
      .frame_done   (done_o),
      .frame_err    (err_o)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Output monitor: counts pulses, shifts in bits, checks spacing and done alignment
   int          n_valid = 0, n_start = 0, n_done = 0, n_err = 0;
   int          n_gap_bad = 0, n_done_bad = 0, vi = 0;
   longint      cyc = 0, last_v = 0;
   logic [31:0] cap = '0;

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (start_o) begin
         n_start <= n_start + 1;
         vi      <= 0;
      end
      if (valid_o) begin
         n_valid <= n_valid + 1;
         vi      <= vi + 1;
         cap     <= {cap[30:0], bit_o};
         last_v  <= cyc;
         if (vi >= 1 && (cyc - last_v) != 16) n_gap_bad <= n_gap_bad + 1;
      end
      if (done_o) begin
         n_done <= n_done + 1;
         if (!(valid_o && vi == 7)) n_done_bad <= n_done_bad + 1;
      end
      if (err_o) n_err <= n_err + 1;
   end

   task automatic idle(input int n);
      line = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // bits[8] is the start slot, bits[7:0] data in line order (MSB first).
   // jmode 0: ideal, 1: bounded random jitter, 2: edge 'shift' +5 with its predecessor +1.
   task automatic send_frame(input logic [8:0] bits, input logic lead,
                             input int jmode, input int shift);
      int   et[$];
      int   prv_off, o, lo, hi, k, n;
      logic b, pb;
      pb = 1'b0;
      prv_off = 0;
      k = 0;
      for (int i = 0; i < 9; i++) begin
         b = bits[8-i];
         for (int s = 0; s < 2; s++) begin
            if ((s == 0 && ((!b && !pb) || (i == 0 && lead))) || (s == 1 && b)) begin
               o = 0;
               if (jmode == 1 && k > 0) begin
                  lo = (prv_off - 3 < -3) ? -3 : prv_off - 3;
                  hi = (prv_off + 3 > 3) ? 3 : prv_off + 3;
                  o  = lo + int'($urandom_range(hi - lo));
               end else if (jmode == 2) begin
                  o = (k == shift) ? 5 : (k == shift - 1) ? 1 : 0;
               end
               et.push_back(i * 16 + s * 8 + o);
               prv_off = o;
               k++;
            end
         end
         pb = b;
      end
      for (int t = 0; t < 152; t++) begin
         n = 0;
         foreach (et[j]) if (et[j] <= t) n++;
         line = n[0];
         @(posedge clk);
         #1;
      end
      line = 1'b0;
   endtask

   typedef struct {
      logic [8:0] bits;
      logic       lead;
      int         jmode;
      int         shift;
      int         e_start;
      int         e_valid;
      int         e_done;
      int         e_err;
      logic [7:0] e_byte;
   } vec_t;

   vec_t vecs[7];
   int   b_valid, b_start, b_done, b_err, b_gap, b_dbad;
   int   mask;

   task automatic snap();
      b_valid = n_valid; b_start = n_start; b_done = n_done;
      b_err   = n_err;   b_gap   = n_gap_bad; b_dbad = n_done_bad;
   endtask

   initial begin : main
      logic got;
      vecs[0] = '{9'h0A5, 1'b0, 0, 0, 1, 8, 1, 0, 8'hA5};
      vecs[1] = '{9'h000, 1'b0, 0, 0, 1, 8, 1, 0, 8'h00};
      vecs[2] = '{9'h0FF, 1'b0, 0, 0, 1, 8, 1, 0, 8'hFF};
      vecs[3] = '{9'h03C, 1'b0, 1, 0, 1, 8, 1, 0, 8'h3C};
      // mid edge of the 4th data bit lands at ph=12 relative to its predecessor
      vecs[4] = '{9'h03C, 1'b0, 2, 4, 1, 3, 0, 1, 8'h01};
      // start slot carries a 1: rise at slot start plus a mid-bit edge
      vecs[5] = '{9'h1A5, 1'b1, 0, 0, 0, 0, 0, 1, 8'h00};
      vecs[6] = '{9'h05A, 1'b0, 0, 0, 1, 8, 1, 0, 8'h5A};

      // reset state, with the line already high for the hunt sequence
      line = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_bit",   int'(bit_o),   0);
      chk("rst_valid", int'(valid_o), 0);
      chk("rst_start", int'(start_o), 0);
      chk("rst_done",  int'(done_o),  0);
      chk("rst_err",   int'(err_o),   0);
      @(negedge clk);
      rst_n = 1'b1;

      // line high, then lows shorter than the arming idle: must stay hunting
      snap();
      repeat (60) @(posedge clk);
      #1;
      for (int r = 0; r < 3; r++) begin
         line = 1'b0;
         repeat (20 + 5 * r + (r == 2 ? 1 : 0)) @(posedge clk);
         #1;
         line = 1'b1;
         repeat (12) @(posedge clk);
         #1;
      end
      repeat (40) @(posedge clk);
      #1;
      chk("hunt_start", n_start - b_start, 0);
      chk("hunt_valid", n_valid - b_valid, 0);
      chk("hunt_done",  n_done - b_done,   0);
      chk("hunt_err",   n_err - b_err,     0);

      for (int v = 0; v < 7; v++) begin
         idle(64);
         snap();
         send_frame(vecs[v].bits, vecs[v].lead, vecs[v].jmode, vecs[v].shift);
         idle(20);
         chk($sformatf("v%0d_start", v), n_start - b_start, vecs[v].e_start);
         chk($sformatf("v%0d_valid", v), n_valid - b_valid, vecs[v].e_valid);
         chk($sformatf("v%0d_done",  v), n_done - b_done,   vecs[v].e_done);
         chk($sformatf("v%0d_err",   v), n_err - b_err,     vecs[v].e_err);
         chk($sformatf("v%0d_done_align", v), n_done_bad - b_dbad, 0);
         if (vecs[v].e_valid > 0) begin
            mask = (1 << vecs[v].e_valid) - 1;
            chk($sformatf("v%0d_bits", v), int'(cap) & mask, int'(vecs[v].e_byte) & mask);
         end
         if (vecs[v].jmode == 0)
            chk($sformatf("v%0d_spacing", v), n_gap_bad - b_gap, 0);
      end

      // reset asserted right after the 4th data bit
      idle(64);
      snap();
      got = 1'b0;
      fork
         send_frame(9'h0F0, 1'b0, 0, 0);
         begin
            for (int c = 0; c < 400 && !got; c++) begin
               @(negedge clk);
               #1;
               if (n_valid - b_valid >= 4) got = 1'b1;
            end
            if (got) begin
               rst_n = 1'b0;
               #1;
               chk("mrst_bit",   int'(bit_o),   0);
               chk("mrst_valid", int'(valid_o), 0);
               chk("mrst_start", int'(start_o), 0);
               chk("mrst_done",  int'(done_o),  0);
               chk("mrst_err",   int'(err_o),   0);
               @(posedge clk);
               @(posedge clk);
               @(negedge clk);
               rst_n = 1'b1;
            end else begin
               chk("mrst_wait_4th_bit", 0, 1);
            end
         end
      join
      idle(20);
      chk("mrst_valid_cnt", n_valid - b_valid, 4);
      chk("mrst_done_cnt",  n_done - b_done,   0);
      chk("mrst_err_cnt",   n_err - b_err,     0);

      idle(64);
      snap();
      send_frame(9'h096, 1'b0, 0, 0);
      idle(20);
      chk("post_rst_valid", n_valid - b_valid, 8);
      chk("post_rst_done",  n_done - b_done,   1);
      chk("post_rst_err",   n_err - b_err,     0);
      chk("post_rst_bits",  int'(cap[7:0]),    8'h96);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
